mult_div_unit: RTL and testbench

- Multi-cycle HI/LO multiply/divide unit in the EX stage of the P7 pipelined MIPS core.
- Consumes the decoder's MultDivStart, MultDivOp, HiLoWe and HiLo strobes, plus the forwarded rs/rt operands.
- Holds the architectural HI and LO registers and runs mult/multu/div/divu over a fixed latency.
- Reports busy so the hazard unit can stall mfhi/mflo/mthi/mtlo and a new start.

---
 rtl/mult_div_unit.sv | 152 +++++++++++++++
 tb/tb_mult_div_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Multi-cycle HI/LO multiply/divide unit for the EX stage. Latches
//            the rs/rt operands and op on an accepted start, then commits the
//            result to HI/LO after a fixed latency. It also services mthi and
//            mtlo writes, and reports busy to the hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic        flush,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // The counter only ever holds values from 0 to (longest latency - 1).
  localparam int c_MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CW   = (c_MAXC > 1) ? $clog2(c_MAXC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [c_CW-1:0]   r_cnt;
  logic              r_busy;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [1:0]        r_op;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;

  logic              w_start_ok;
  logic              w_hilo_ok;
  logic              w_done;
  logic [63:0]       w_a_ext;
  logic [63:0]       w_b_ext;
  logic [63:0]       w_prod;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [31:0]       w_ua;
  logic [31:0]       w_ub;
  logic [31:0]       w_div_by;
  logic [31:0]       w_uq;
  logic [31:0]       w_ur;
  logic [31:0]       w_q;
  logic [31:0]       w_r;

  // A flushed instruction never starts work. Start has priority over mthi/mtlo.
  assign w_start_ok = start & ~flush & ~r_busy;
  assign w_hilo_ok  = hilo_we & ~flush & ~r_busy & ~start;
  assign w_done     = (r_state != S_IDLE) && (r_cnt == '0);

  // One 64x64 multiplier serves both mult and multu. The low 64 bits of the
  // product of the sign-extended operands equal the signed 32x32 product.
  assign w_a_ext = r_op[0] ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
  assign w_b_ext = r_op[0] ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed division is done on the magnitudes, and the signs are fixed up
  // afterwards. abs(0x80000000) stays 0x80000000 as an unsigned value. As a
  // result, 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
  assign w_neg_a  = r_op[0] & r_a[31];
  assign w_neg_b  = r_op[0] & r_b[31];
  assign w_ua     = w_neg_a ? (32'd0 - r_a) : r_a;
  assign w_ub     = w_neg_b ? (32'd0 - r_b) : r_b;
  assign w_div_by = (w_ub == 32'd0) ? 32'd1 : w_ub;  // keeps the divider X-free; result unused on /0
  assign w_uq     = w_ua / w_div_by;
  assign w_ur     = w_ua % w_div_by;
  assign w_q      = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
  assign w_r      = w_neg_a ? (32'd0 - w_ur) : w_ur;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: leave IDLE on an accepted start, and return on commit.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next_state = op[1] ? S_DIV : S_MULT;
      S_MULT,
      S_DIV:   if (w_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand latch, latency counter and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_op   <= 2'd0;
    end else if (w_start_ok) begin
      r_a    <= a;
      r_b    <= b;
      r_op   <= op;
      r_busy <= 1'b1;
      r_cnt  <= op[1] ? c_CW'(DIV_CYCLES - 1) : c_CW'(MULT_CYCLES - 1);
    end else if (w_done) begin
      r_busy <= 1'b0;
    end else if (r_state != S_IDLE) begin
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  // HI/LO change only on commit, on an accepted mthi/mtlo, or on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_done) begin
      if (r_state == S_MULT) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end else if (r_b != 32'd0) begin
        r_hi <= w_r;
        r_lo <= w_q;
      end
    end else if (w_hilo_ok) begin
      if (hilo_sel) r_hi <= a;
      else          r_lo <= a;
    end
  end

  assign busy     = r_busy;
  assign md_stall = start | r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed self-checking bench for mult_div_unit. Uses hand-computed
//            HI/LO results, busy timing and ignore rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_we;
  logic        hilo_sel;
  logic        flush;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] c_MULTU = 2'b00;
  localparam logic [1:0] c_MULT  = 2'b01;
  localparam logic [1:0] c_DIVU  = 2'b10;
  localparam logic [1:0] c_DIV   = 2'b11;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hilo_we  (hilo_we),
    .hilo_sel (hilo_sel),
    .flush    (flush),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start for exactly one edge (this edge is E0).
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0;
  endtask

  // After E0: busy must stay high through E_{n-1} and drop at E_n.
  task automatic run_out(input int n, input string tag);
    check({tag, " busy@E0"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i < n; i++) step();
    check({tag, " busy@En-1"}, {31'd0, busy}, 32'd1);
    step();
    check({tag, " busy@En"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    hilo_we = 1'b0; hilo_sel = 1'b0; flush = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst md_stall", {31'd0, md_stall}, 32'd0);

    // mult -2 * 3. md_stall follows start combinationally.
    start = 1'b1; op = c_MULT; a = 32'hFFFFFFFE; b = 32'd3;
    #1 check("md_stall on start", {31'd0, md_stall}, 32'd1);
    step(); start = 1'b0;
    run_out(5, "mult");
    check("mult hi", hi, 32'hFFFFFFFF);
    check("mult lo", lo, 32'hFFFFFFFA);

    // multu with the operand inputs disturbed while busy.
    issue(c_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 1; i <= 4; i++) begin
      a = 32'h1234 * i; b = 32'h77 + i;
      step();
      check("multu hold hi", hi, 32'hFFFFFFFF);
      check("multu hold lo", lo, 32'hFFFFFFFA);
      check("multu busy", {31'd0, busy}, 32'd1);
    end
    step();
    check("multu busy@E5", {31'd0, busy}, 32'd0);
    check("multu hi", hi, 32'hFFFFFFFE);
    check("multu lo", lo, 32'h00000001);

    // div -7 / 2, with flush raised mid-operation (edges E3..E5).
    issue(c_DIV, 32'hFFFFFFF9, 32'd2);
    for (int i = 1; i <= 9; i++) begin
      flush = (i >= 3 && i <= 5);
      step();
      check("div busy", {31'd0, busy}, 32'd1);
    end
    flush = 1'b0;
    step();
    check("div busy@E10", {31'd0, busy}, 32'd0);
    check("div lo", lo, 32'hFFFFFFFD);
    check("div hi", hi, 32'hFFFFFFFF);

    // mthi 0x11 / mtlo 0x22, then divu by zero leaves them unchanged.
    hilo_we = 1'b1; hilo_sel = 1'b1; a = 32'h11; step();
    hilo_sel = 1'b0; a = 32'h22; step();
    hilo_we = 1'b0;
    issue(c_DIVU, 32'd7, 32'd0);
    run_out(10, "divu0");
    check("divu0 hi", hi, 32'h11);
    check("divu0 lo", lo, 32'h22);

    // Signed overflow case and a couple of ordinary quotients.
    issue(c_DIV, 32'h80000000, 32'hFFFFFFFF);
    run_out(10, "divovf");
    check("divovf lo", lo, 32'h80000000);
    check("divovf hi", hi, 32'h0);
    issue(c_DIVU, 32'd100, 32'd7);
    run_out(10, "divu");
    check("divu lo", lo, 32'd14);
    check("divu hi", hi, 32'd2);
    issue(c_DIV, 32'd7, 32'hFFFFFFFE);
    run_out(10, "div7n2");
    check("div7n2 lo", lo, 32'hFFFFFFFD);
    check("div7n2 hi", hi, 32'd1);

    // mthi / mtlo take effect one cycle after the write.
    hilo_we = 1'b1; hilo_sel = 1'b1; a = 32'h12345678; step();
    check("mthi", hi, 32'h12345678);
    hilo_sel = 1'b0; a = 32'hCAFEBABE; step();
    hilo_we = 1'b0;
    check("mtlo", lo, 32'hCAFEBABE);
    check("mtlo keeps hi", hi, 32'h12345678);

    // mtlo while busy is ignored.
    issue(c_MULT, 32'd2, 32'd3);
    hilo_we = 1'b1; hilo_sel = 1'b0; a = 32'hDEAD; step();
    hilo_we = 1'b0;
    check("mtlo busy ignored", lo, 32'hCAFEBABE);
    for (int i = 2; i <= 5; i++) step();
    check("mult6 busy@E5", {31'd0, busy}, 32'd0);
    check("mult6 lo", lo, 32'd6);
    check("mult6 hi", hi, 32'd0);

    // Start and mthi together: only the multiply runs.
    hilo_we = 1'b1; hilo_sel = 1'b1;
    issue(c_MULTU, 32'd4, 32'd5);
    hilo_we = 1'b0;
    check("start wins hi", hi, 32'd0);
    for (int i = 1; i <= 5; i++) step();
    check("mult20 lo", lo, 32'd20);
    check("mult20 hi", hi, 32'd0);

    // A flushed start is not accepted, but it still raises md_stall.
    flush = 1'b1; start = 1'b1; op = c_MULT; a = 32'd9; b = 32'd9;
    #1 check("flush md_stall", {31'd0, md_stall}, 32'd1);
    step();
    start = 1'b0; flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    step();
    check("flush lo", lo, 32'd20);

    // A second start at E3 of a mult is ignored.
    issue(c_MULT, 32'd3, 32'd3);
    step(); step();
    start = 1'b1; op = c_DIVU; a = 32'd100; b = 32'd10;
    step();
    start = 1'b0;
    step(); step();
    check("restart busy@E5", {31'd0, busy}, 32'd0);
    check("restart lo", lo, 32'd9);
    check("restart hi", hi, 32'd0);

    // Reset at E2 of a divide, then a fresh multiply.
    issue(c_DIV, 32'd100, 32'd3);
    step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    issue(c_MULT, 32'd6, 32'd7);
    run_out(5, "postrst");
    check("postrst lo", lo, 32'd42);
    check("postrst hi", hi, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
